// File: rtl/ddr3_axis_ctrl_if.sv
//==============================================================================
// Module      : ddr3_axis_ctrl_if
// Description : Byte-stream and DDR3 application-port bundle for ddr3_axis_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ddr3_axis_ctrl_if #(
  parameter int ADDR_WIDTH = 28
) ();
  // Signal suffixes are relative to the controller: _i enters it, _o leaves it.
  logic                  s_tvalid_i;
  logic                  s_tready_o;
  logic                  s_tlast_i;
  logic [7:0]            s_tdata_i;
  logic                  m_tvalid_o;
  logic                  m_tready_i;
  logic                  m_tlast_o;
  logic [7:0]            m_tdata_o;
  logic [2:0]            app_cmd_o;
  logic                  app_cmd_en_o;
  logic                  app_cmd_rdy_i;
  logic [ADDR_WIDTH-1:0] app_addr_o;
  logic [5:0]            app_burst_number_o;
  logic [127:0]          app_wr_data_o;
  logic                  app_wr_en_o;
  logic                  app_wr_end_o;
  logic                  app_wr_rdy_i;
  logic [15:0]           app_wr_mask_o;
  logic [127:0]          app_rd_data_i;
  logic                  app_rd_valid_i;
  logic                  app_rd_end_i;

  modport master (
    input  s_tvalid_i, s_tlast_i, s_tdata_i, m_tready_i,
    input  app_cmd_rdy_i, app_wr_rdy_i, app_rd_data_i, app_rd_valid_i, app_rd_end_i,
    output s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o,
    output app_cmd_o, app_cmd_en_o, app_addr_o, app_burst_number_o,
    output app_wr_data_o, app_wr_en_o, app_wr_end_o, app_wr_mask_o
  );

  modport slave (
    output s_tvalid_i, s_tlast_i, s_tdata_i, m_tready_i,
    output app_cmd_rdy_i, app_wr_rdy_i, app_rd_data_i, app_rd_valid_i, app_rd_end_i,
    input  s_tready_o, m_tvalid_o, m_tlast_o, m_tdata_o,
    input  app_cmd_o, app_cmd_en_o, app_addr_o, app_burst_number_o,
    input  app_wr_data_o, app_wr_en_o, app_wr_end_o, app_wr_mask_o
  );
endinterface

`default_nettype wire

// File: rtl/ddr3_axis_ctrl.sv
//==============================================================================
// Module      : ddr3_axis_ctrl
// Description : Turns 8-bit command packets into single-burst DDR3 app commands
//               and streams 128-bit read words back as 16-byte packets.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ddr3_axis_ctrl #(
  parameter int         ADDR_WIDTH = 28,
  parameter logic [2:0] CMD_WRITE  = 3'b000,
  parameter logic [2:0] CMD_READ   = 3'b001,
  parameter int         TIMEOUT    = 1023
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             calib_i,
  ddr3_axis_ctrl_if.master      bus,
  output logic                  busy_o,
  output logic [7:0]            err_count_o
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IDLE  = 4'd1,
    S_ADDR  = 4'd2,
    S_WDAT  = 4'd3,
    S_WCMD  = 4'd4,
    S_RCMD  = 4'd5,
    S_RWAIT = 4'd6,
    S_RSEND = 4'd7,
    S_DROP  = 4'd8
  } state_t;

  localparam logic [9:0] c_timeout = 10'(TIMEOUT);

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_is_write;
  logic [14:0]    r_addr;
  logic [3:0]     r_cnt;
  logic [9:0]     r_timer;
  logic [127:0]   r_data;
  logic [7:0]     r_err;
  logic           r_cmd_pend;
  logic           r_wr_pend;
  logic           w_cmd_pend_nxt;
  logic           w_wr_pend_nxt;
  logic           w_err;
  logic           w_s_ready;
  logic           w_take;

  assign w_s_ready = (r_state == S_IDLE) || (r_state == S_ADDR) ||
                     (r_state == S_WDAT) || (r_state == S_DROP);
  assign w_take    = bus.s_tvalid_i & w_s_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err          = 1'b0;
    w_cmd_pend_nxt = r_cmd_pend;
    w_wr_pend_nxt  = r_wr_pend;
    case (r_state)
      S_INIT:  if (calib_i) w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_take) begin
          if (bus.s_tlast_i) w_err       = 1'b1;
          else               w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_take) begin
          if (!r_is_write) begin
            if (bus.s_tlast_i) w_state_nxt = S_RCMD;
            else begin w_err = 1'b1; w_state_nxt = S_DROP; end
          end else if (bus.s_tlast_i) begin
            w_err = 1'b1; w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WDAT;
          end
        end
      end
      S_WDAT: begin
        if (w_take) begin
          if (r_cnt == 4'd15) begin
            if (bus.s_tlast_i) w_state_nxt = S_WCMD;
            else begin w_err = 1'b1; w_state_nxt = S_DROP; end
          end else if (bus.s_tlast_i) begin
            w_err = 1'b1; w_state_nxt = S_IDLE;
          end
        end
      end
      S_WCMD: begin
        // Command and data handshakes retire independently, in any order.
        if (r_cmd_pend && bus.app_cmd_rdy_i) w_cmd_pend_nxt = 1'b0;
        if (r_wr_pend && bus.app_wr_rdy_i)   w_wr_pend_nxt  = 1'b0;
        if (!w_cmd_pend_nxt && !w_wr_pend_nxt) w_state_nxt = S_IDLE;
      end
      S_RCMD:  if (bus.app_cmd_rdy_i) w_state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (bus.app_rd_valid_i) begin
          w_state_nxt = S_RSEND;
          if (!bus.app_rd_end_i) w_err = 1'b1;
        end else if (r_timer == c_timeout) begin
          w_err = 1'b1; w_state_nxt = S_IDLE;
        end
      end
      S_RSEND: if (bus.m_tready_i && r_cnt == 4'd15) w_state_nxt = S_IDLE;
      S_DROP:  if (w_take && bus.s_tlast_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
    if (bus.app_rd_valid_i && r_state != S_RWAIT) w_err = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_is_write <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_data     <= '0;
      r_err      <= '0;
      r_cmd_pend <= 1'b0;
      r_wr_pend  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_take) begin
        r_is_write    <= bus.s_tdata_i[7];
        r_addr[14:8]  <= bus.s_tdata_i[6:0];
      end
      if (r_state == S_ADDR && w_take) r_addr[7:0] <= bus.s_tdata_i;

      if (r_state == S_WDAT) begin
        if (w_take) begin
          r_cnt  <= r_cnt + 4'd1;
          r_data <= {r_data[119:0], bus.s_tdata_i};
        end
      end else if (r_state == S_RSEND) begin
        if (bus.m_tready_i) begin
          r_cnt  <= r_cnt + 4'd1;
          r_data <= {r_data[119:0], 8'h00};
        end
      end else begin
        r_cnt <= '0;
      end
      if (r_state == S_RWAIT && bus.app_rd_valid_i) r_data <= bus.app_rd_data_i;

      r_timer <= (r_state == S_RWAIT) ? r_timer + 10'd1 : 10'd0;

      // Pending flags sit at 1 outside WCMD so both enables rise on entry.
      if (r_state == S_WCMD) begin
        r_cmd_pend <= w_cmd_pend_nxt;
        r_wr_pend  <= w_wr_pend_nxt;
      end else begin
        r_cmd_pend <= 1'b1;
        r_wr_pend  <= 1'b1;
      end

      if (w_err && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  assign bus.s_tready_o         = w_s_ready;
  assign bus.m_tvalid_o         = (r_state == S_RSEND);
  assign bus.m_tlast_o          = (r_state == S_RSEND) && (r_cnt == 4'd15);
  assign bus.m_tdata_o          = r_data[127:120];
  assign bus.app_cmd_o          = (r_state == S_WCMD) ? CMD_WRITE : CMD_READ;
  assign bus.app_cmd_en_o       = (r_state == S_RCMD) || (r_state == S_WCMD && r_cmd_pend);
  assign bus.app_addr_o         = {{(ADDR_WIDTH-18){1'b0}}, r_addr, 3'b000};
  assign bus.app_burst_number_o = 6'd0;
  assign bus.app_wr_data_o      = r_data;
  assign bus.app_wr_en_o        = (r_state == S_WCMD) && r_wr_pend;
  assign bus.app_wr_end_o       = (r_state == S_WCMD) && r_wr_pend;
  assign bus.app_wr_mask_o      = 16'd0;
  assign busy_o                 = (r_state != S_IDLE);
  assign err_count_o            = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ddr3_axis_ctrl.sv
//==============================================================================
// Module      : tb_ddr3_axis_ctrl
// Description : Directed self-checking bench for ddr3_axis_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ddr3_axis_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       calib = 1'b0;
  logic       busy;
  logic [7:0] err_count;
  int         n_checks = 0;
  int         n_fail   = 0;

  ddr3_axis_ctrl_if #(.ADDR_WIDTH(28)) bus ();

  ddr3_axis_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .calib_i     (calib),
    .bus         (bus),
    .busy_o      (busy),
    .err_count_o (err_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    bus.s_tvalid_i = 1'b1;
    bus.s_tdata_i  = b;
    bus.s_tlast_i  = last;
    while (!bus.s_tready_o && n < 100) begin
      tick();
      n++;
    end
    check("s_tready_wait", 128'(n < 100), 128'(1));
    tick();
    bus.s_tvalid_i = 1'b0;
    bus.s_tlast_i  = 1'b0;
  endtask

  initial begin
    logic [127:0] word;
    int           idx;
    int           cyc;
    logic         rdy;
    logic         saw_valid;

    bus.s_tvalid_i = 1'b0; bus.s_tlast_i = 1'b0; bus.s_tdata_i = 8'h00;
    bus.m_tready_i = 1'b0; bus.app_cmd_rdy_i = 1'b0; bus.app_wr_rdy_i = 1'b0;
    bus.app_rd_data_i = '0; bus.app_rd_valid_i = 1'b0; bus.app_rd_end_i = 1'b0;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_busy",    128'(busy), 128'(1));
    check("rst_tready",  128'(bus.s_tready_o), 128'(0));
    check("rst_mvalid",  128'(bus.m_tvalid_o), 128'(0));
    check("rst_cmd_en",  128'(bus.app_cmd_en_o), 128'(0));
    check("rst_wr_en",   128'(bus.app_wr_en_o), 128'(0));
    check("rst_addr",    128'(bus.app_addr_o), 128'(0));
    check("rst_err",     128'(err_count), 128'(0));

    // Before calibration nothing is accepted
    bus.s_tvalid_i = 1'b1; bus.s_tdata_i = 8'h81;
    repeat (5) begin
      tick();
      check("precal_tready", 128'(bus.s_tready_o), 128'(0));
      check("precal_cmd_en", 128'(bus.app_cmd_en_o), 128'(0));
    end
    bus.s_tvalid_i = 1'b0;
    calib = 1'b1;
    tick();
    check("cal_idle_busy", 128'(busy), 128'(0));
    check("cal_tready",    128'(bus.s_tready_o), 128'(1));

    // Write to word 0x0123, data bytes 00..0F
    send_byte(8'h81, 1'b0);
    send_byte(8'h23, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'(i == 15));
    check("wr_cmd_en",  128'(bus.app_cmd_en_o), 128'(1));
    check("wr_cmd",     128'(bus.app_cmd_o), 128'(3'b000));
    check("wr_addr",    128'(bus.app_addr_o), 128'(28'h0000918));
    check("wr_data",    bus.app_wr_data_o, 128'h000102030405060708090A0B0C0D0E0F);
    check("wr_en",      128'(bus.app_wr_en_o), 128'(1));
    check("wr_end",     128'(bus.app_wr_end_o), 128'(1));
    bus.app_cmd_rdy_i = 1'b1;
    tick();
    bus.app_cmd_rdy_i = 1'b0;
    repeat (5) begin
      check("wr_cmd_dropped", 128'(bus.app_cmd_en_o), 128'(0));
      check("wr_en_held",     128'(bus.app_wr_en_o), 128'(1));
      tick();
    end
    bus.app_wr_rdy_i = 1'b1;
    tick();
    bus.app_wr_rdy_i = 1'b0;
    check("wr_en_done",  128'(bus.app_wr_en_o), 128'(0));
    check("wr_end_done", 128'(bus.app_wr_end_o), 128'(0));
    check("wr_cmd_done", 128'(bus.app_cmd_en_o), 128'(0));
    check("wr_idle",     128'(busy), 128'(0));

    // Read from word 0x0123 with stalled command acceptance
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b1);
    check("rd_cmd_en", 128'(bus.app_cmd_en_o), 128'(1));
    check("rd_cmd",    128'(bus.app_cmd_o), 128'(3'b001));
    check("rd_addr",   128'(bus.app_addr_o), 128'(28'h0000918));
    tick(); tick();
    check("rd_cmd_en_stall", 128'(bus.app_cmd_en_o), 128'(1));
    bus.app_cmd_rdy_i = 1'b1;
    tick();
    bus.app_cmd_rdy_i = 1'b0;
    check("rd_wait_cmd_en", 128'(bus.app_cmd_en_o), 128'(0));
    check("rd_wait_busy",   128'(busy), 128'(1));
    check("rd_wait_mvalid", 128'(bus.m_tvalid_o), 128'(0));
    repeat (3) tick();
    word = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
    bus.app_rd_data_i = word; bus.app_rd_valid_i = 1'b1; bus.app_rd_end_i = 1'b1;
    tick();
    bus.app_rd_valid_i = 1'b0; bus.app_rd_end_i = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 200) begin
      rdy = 1'($urandom_range(0, 1));
      bus.m_tready_i = rdy;
      check("rs_valid", 128'(bus.m_tvalid_o), 128'(1));
      check("rs_data",  128'(bus.m_tdata_o), 128'(word[127-8*idx -: 8]));
      check("rs_last",  128'(bus.m_tlast_o), 128'(idx == 15));
      tick();
      if (rdy) idx++;
      cyc++;
    end
    bus.m_tready_i = 1'b0;
    check("rs_count",  128'(idx), 128'(16));
    check("rs_mvalid", 128'(bus.m_tvalid_o), 128'(0));
    check("rs_idle",   128'(busy), 128'(0));
    check("rs_err",    128'(err_count), 128'(0));

    // Read timeout: 1024 cycles in wait state without data
    bus.app_cmd_rdy_i = 1'b1;
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    tick();
    saw_valid = 1'b0;
    repeat (1023) begin
      tick();
      if (bus.m_tvalid_o) saw_valid = 1'b1;
    end
    check("to_still_busy", 128'(busy), 128'(1));
    check("to_err_before", 128'(err_count), 128'(0));
    tick();
    check("to_idle",   128'(busy), 128'(0));
    check("to_err",    128'(err_count), 128'(1));
    check("to_no_rsp", 128'(saw_valid | bus.m_tvalid_o), 128'(0));

    // Write cut short by tlast on data byte 10
    send_byte(8'h80, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'hA0 + i), 1'(i == 9));
    check("short_wr_idle",  128'(busy), 128'(0));
    check("short_wr_err",   128'(err_count), 128'(2));
    check("short_wr_cmd",   128'(bus.app_cmd_en_o), 128'(0));
    check("short_wr_wr_en", 128'(bus.app_wr_en_o), 128'(0));

    // Five-byte read: error, tail dropped
    send_byte(8'h01, 1'b0);
    send_byte(8'h23, 1'b0);
    check("long_rd_err",  128'(err_count), 128'(3));
    check("long_rd_drop", 128'(bus.app_cmd_en_o), 128'(0));
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    check("drop_idle", 128'(busy), 128'(0));

    // Following read works; reset while byte index 7 is presented
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b1);
    check("rd2_addr", 128'(bus.app_addr_o), 128'(28'h0000010));
    tick();
    bus.app_rd_data_i = 128'h00112233445566778899AABBCCDDEEFF;
    bus.app_rd_valid_i = 1'b1; bus.app_rd_end_i = 1'b1;
    tick();
    bus.app_rd_valid_i = 1'b0; bus.app_rd_end_i = 1'b0;
    bus.m_tready_i = 1'b1;
    repeat (7) tick();
    check("rd2_byte7",  128'(bus.m_tdata_o), 128'(8'h77));
    check("rd2_valid7", 128'(bus.m_tvalid_o), 128'(1));
    reset = 1'b1;
    tick();
    check("mid_rst_mvalid", 128'(bus.m_tvalid_o), 128'(0));
    check("mid_rst_busy",   128'(busy), 128'(1));
    check("mid_rst_tready", 128'(bus.s_tready_o), 128'(0));
    check("mid_rst_err",    128'(err_count), 128'(0));
    reset = 1'b0;
    bus.m_tready_i = 1'b0;
    tick();
    check("post_rst_idle", 128'(busy), 128'(0));

    // Stray read data outside the wait state saturates the error counter
    bus.app_rd_valid_i = 1'b1;
    tick();
    check("stray_rd_err", 128'(err_count), 128'(1));
    repeat (299) tick();
    bus.app_rd_valid_i = 1'b0;
    tick();
    check("err_saturate", 128'(err_count), 128'(8'hFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
